uart_fx_frame_engine: RTL and testbench

//  Length-framed, multi-byte successor to the single-byte UART echo effect path.

---
 rtl/uart_fx_frame_engine.sv | 310 +++++++++++++++++++++++++++++++
 tb/tb_uart_fx_frame_engine.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_fx_frame_engine.sv
// uart_fx_frame_engine
//   Length-framed effect path between the UART byte ports and the host link.
//   Accepts {HEADER, LEN, payload}, filters each payload byte with the mode
//   latched at LEN, stages it in a commit/rollback FIFO and retransmits
//   {HEADER, LEN, filtered payload} once the whole frame is committed.
//
//   i_clk, i_rst_n        clock, async active-low reset
//   i_rx_dv, i_rx_byte    received byte strobe / data
//   i_tx_active           UART TX busy
//   i_tx_done             UART TX done (rising edge used)
//   i_mode                0 bypass, 1 clip, 2 bitcrush, 3 half-gain
//   o_tx_dv, o_tx_byte    transmit strobe / byte (byte held between strobes)
//   o_frame_err           1-cycle pulse when a frame is dropped
//   o_busy                TX FSM not idle
//   o_fifo_level          committed, unread FIFO entries
//
//   state  | meaning
//   R_HDR  | hunting for HEADER
//   R_LEN  | expecting LEN byte
//   R_DATA | writing payload tentatively at wr_tmp
//   T_IDLE | waiting for a committed frame length
//   T_HDR  | ready to send HEADER
//   T_LEN  | ready to send LEN
//   T_DATA | ready to send next payload byte
//   T_WAIT | byte handed to UART, waiting for tx_done edge
module uart_fx_frame_engine #(
    parameter logic [7:0] HEADER       = 8'hAA,
    parameter int         MAX_LEN      = 16,
    parameter int         FIFO_DEPTH   = 64,
    parameter logic [7:0] CLIP_LEVEL   = 8'd150,
    parameter int         CRUSH_BITS   = 5,
    parameter int         TIMEOUT_CLKS = 25_000
) (
    input  logic                             i_clk,
    input  logic                             i_rst_n,
    input  logic                             i_rx_dv,
    input  logic [7:0]                       i_rx_byte,
    input  logic                             i_tx_active,
    input  logic                             i_tx_done,
    input  logic [1:0]                       i_mode,
    output logic                             o_tx_dv,
    output logic [7:0]                       o_tx_byte,
    output logic                             o_frame_err,
    output logic                             o_busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  o_fifo_level
);

    localparam int         AW         = $clog2(FIFO_DEPTH);
    localparam int         LW         = $clog2(FIFO_DEPTH + 1);
    localparam int         TW         = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [7:0] MAX_LEN_B  = 8'(MAX_LEN);
    localparam logic [7:0] CRUSH_MASK = 8'hFF << CRUSH_BITS;

    typedef enum logic [1:0] {R_HDR, R_LEN, R_DATA} rx_state_e;
    typedef enum logic [2:0] {T_IDLE, T_HDR, T_LEN, T_DATA, T_WAIT} tx_state_e;

    function automatic logic [7:0] fx_filter(input logic [1:0] mode, input logic [7:0] x);
        case (mode)
            2'd1:    return (x > CLIP_LEVEL) ? CLIP_LEVEL : x;
            2'd2:    return x & CRUSH_MASK;
            2'd3:    return {1'b0, x[7:1]};
            default: return x;
        endcase
    endfunction

    rx_state_e         rx_state_q, rx_state_d;
    logic [7:0]        rx_len_q, rx_len_d;
    logic [7:0]        rx_cnt_q, rx_cnt_d;
    logic [1:0]        rx_mode_q, rx_mode_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     wr_tmp_q, wr_tmp_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic              err_q, err_d;
    logic              fifo_we, lq_push, lq_pop, lq_full, timeout, overflow;
    logic [15:0]       occ;
    logic [1:0]        pending;

    tx_state_e         tx_state_q, tx_state_d;
    tx_state_e         tx_next_q, tx_next_d;
    logic [7:0]        tx_len_q, tx_len_d;
    logic [7:0]        tx_rem_q, tx_rem_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     level_q, level_d;
    logic [7:0]        hold_q, tx_mux;
    logic              done_q, done_rise, tx_fire, fifo_rd;

    logic [7:0]        lq_mem_q [2];
    logic              lq_wr_q, lq_rd_q;
    logic [1:0]        lq_cnt_q;
    logic [7:0]        fifo_mem [FIFO_DEPTH];

    // The frame currently owned by the TX FSM still counts as pending, so two
    // frames in flight (one sending or blocked, one queued) close the queue.
    assign pending  = lq_cnt_q + {1'b0, (tx_state_q != T_IDLE)};
    assign lq_full  = (pending >= 2'd2);
    assign lq_pop   = (tx_state_q == T_IDLE) && (lq_cnt_q != 2'd0);
    assign occ      = 16'(level_q) + 16'(rx_cnt_q);
    assign overflow = (occ >= 16'(FIFO_DEPTH));
    assign timeout  = (rx_state_q != R_HDR) && !i_rx_dv && (tmo_q == '0);

    // ---------------- RX FSM ----------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rx_state_q <= R_HDR;
            rx_len_q   <= '0;
            rx_cnt_q   <= '0;
            rx_mode_q  <= '0;
            wr_ptr_q   <= '0;
            wr_tmp_q   <= '0;
            tmo_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_len_q   <= rx_len_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_mode_q  <= rx_mode_d;
            wr_ptr_q   <= wr_ptr_d;
            wr_tmp_q   <= wr_tmp_d;
            tmo_q      <= tmo_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_len_d   = rx_len_q;
        rx_cnt_d   = rx_cnt_q;
        rx_mode_d  = rx_mode_q;
        wr_ptr_d   = wr_ptr_q;
        wr_tmp_d   = wr_tmp_q;
        err_d      = 1'b0;
        fifo_we    = 1'b0;
        lq_push    = 1'b0;

        // idle down-counter, reloaded by every received byte
        if (i_rx_dv)
            tmo_d = TW'(TIMEOUT_CLKS - 1);
        else if (rx_state_q != R_HDR && tmo_q != '0)
            tmo_d = tmo_q - TW'(1);
        else
            tmo_d = tmo_q;

        case (rx_state_q)
            R_HDR: begin
                if (i_rx_dv && i_rx_byte == HEADER)
                    rx_state_d = R_LEN;
            end
            R_LEN: begin
                if (timeout) begin
                    err_d      = 1'b1;
                    rx_state_d = R_HDR;
                end else if (i_rx_dv) begin
                    if (i_rx_byte == 8'd0 || i_rx_byte > MAX_LEN_B || lq_full) begin
                        err_d      = 1'b1;
                        rx_state_d = R_HDR;
                    end else begin
                        rx_len_d   = i_rx_byte;
                        rx_mode_d  = i_mode;
                        rx_cnt_d   = '0;
                        wr_tmp_d   = wr_ptr_q;
                        rx_state_d = R_DATA;
                    end
                end
            end
            R_DATA: begin
                if (timeout || (i_rx_dv && overflow)) begin
                    err_d      = 1'b1;
                    wr_tmp_d   = wr_ptr_q;
                    rx_cnt_d   = '0;
                    rx_state_d = R_HDR;
                end else if (i_rx_dv) begin
                    fifo_we  = 1'b1;
                    wr_tmp_d = wr_tmp_q + AW'(1);
                    rx_cnt_d = rx_cnt_q + 8'd1;
                    if ((rx_cnt_q + 8'd1) == rx_len_q) begin
                        wr_ptr_d   = wr_tmp_q + AW'(1);
                        lq_push    = 1'b1;
                        rx_cnt_d   = '0;
                        rx_state_d = R_HDR;
                    end
                end
            end
            default: rx_state_d = R_HDR;
        endcase
    end

    assign o_frame_err = err_q;

    always_ff @(posedge i_clk) begin
        if (fifo_we)
            fifo_mem[wr_tmp_q] <= fx_filter(rx_mode_q, i_rx_byte);
    end

    // ---------------- length queue ----------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            lq_mem_q[0] <= '0;
            lq_mem_q[1] <= '0;
            lq_wr_q     <= 1'b0;
            lq_rd_q     <= 1'b0;
            lq_cnt_q    <= '0;
        end else begin
            if (lq_push) begin
                lq_mem_q[lq_wr_q] <= rx_len_q;
                lq_wr_q           <= ~lq_wr_q;
            end
            if (lq_pop)
                lq_rd_q <= ~lq_rd_q;
            lq_cnt_q <= lq_cnt_q + {1'b0, lq_push} - {1'b0, lq_pop};
        end
    end

    // ---------------- TX FSM ----------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tx_state_q <= T_IDLE;
            tx_next_q  <= T_IDLE;
            tx_len_q   <= '0;
            tx_rem_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            hold_q     <= '0;
            done_q     <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_next_q  <= tx_next_d;
            tx_len_q   <= tx_len_d;
            tx_rem_q   <= tx_rem_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            done_q     <= i_tx_done;
            if (tx_fire)
                hold_q <= tx_mux;
        end
    end

    assign done_rise = i_tx_done && !done_q;
    assign level_d   = level_q + (lq_push ? LW'(rx_len_q) : LW'(0)) - (fifo_rd ? LW'(1) : LW'(0));

    always_comb begin
        tx_state_d = tx_state_q;
        tx_next_d  = tx_next_q;
        tx_len_d   = tx_len_q;
        tx_rem_d   = tx_rem_q;
        rd_ptr_d   = rd_ptr_q;
        case (tx_state_q)
            T_IDLE: begin
                if (lq_pop) begin
                    tx_len_d   = lq_mem_q[lq_rd_q];
                    tx_rem_d   = lq_mem_q[lq_rd_q];
                    tx_state_d = T_HDR;
                end
            end
            T_HDR: begin
                if (!i_tx_active) begin
                    tx_next_d  = T_LEN;
                    tx_state_d = T_WAIT;
                end
            end
            T_LEN: begin
                if (!i_tx_active) begin
                    tx_next_d  = T_DATA;
                    tx_state_d = T_WAIT;
                end
            end
            T_DATA: begin
                if (!i_tx_active) begin
                    rd_ptr_d   = rd_ptr_q + AW'(1);
                    tx_rem_d   = tx_rem_q - 8'd1;
                    tx_next_d  = (tx_rem_q == 8'd1) ? T_IDLE : T_DATA;
                    tx_state_d = T_WAIT;
                end
            end
            T_WAIT: begin
                if (done_rise)
                    tx_state_d = tx_next_q;
            end
            default: tx_state_d = T_IDLE;
        endcase
    end

    // Strobe is combinational so HEADER leaves two edges after the last
    // payload byte; the byte register keeps the value between strobes.
    always_comb begin
        tx_fire = 1'b0;
        tx_mux  = hold_q;
        case (tx_state_q)
            T_HDR: begin
                tx_fire = !i_tx_active;
                tx_mux  = HEADER;
            end
            T_LEN: begin
                tx_fire = !i_tx_active;
                tx_mux  = tx_len_q;
            end
            T_DATA: begin
                tx_fire = !i_tx_active;
                tx_mux  = fifo_mem[rd_ptr_q];
            end
            default: ;
        endcase
        fifo_rd   = tx_fire && (tx_state_q == T_DATA);
        o_tx_dv   = tx_fire;
        o_tx_byte = tx_fire ? tx_mux : hold_q;
    end

    assign o_busy       = (tx_state_q != T_IDLE);
    assign o_fifo_level = level_q;

endmodule

// File: tb/tb_uart_fx_frame_engine.sv
`timescale 1ns/1ps
module tb_uart_fx_frame_engine;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_dv;
    logic [7:0] rx_byte;
    logic       tx_active;
    logic       tx_done;
    logic [1:0] mode;
    logic       tx_dv;
    logic [7:0] tx_byte;
    logic       frame_err;
    logic       busy;
    logic [6:0] fifo_level;

    logic       tx_hold;
    logic       tx_busy_m;

    int         n_cmp = 0;
    int         n_mis = 0;
    int         cyc = 0;
    int         err_cnt = 0;
    int         dv_cnt = 0;
    int         viol = 0;
    int         first_dv_edge = -1;
    int         last_rx_edge = 0;
    logic [7:0] exp_q [$];
    logic [7:0] pl [32];

    always #20 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    assign tx_active = tx_hold | tx_busy_m;

    uart_fx_frame_engine dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_rx_dv      (rx_dv),
        .i_rx_byte    (rx_byte),
        .i_tx_active  (tx_active),
        .i_tx_done    (tx_done),
        .i_mode       (mode),
        .o_tx_dv      (tx_dv),
        .o_tx_byte    (tx_byte),
        .o_frame_err  (frame_err),
        .o_busy       (busy),
        .o_fifo_level (fifo_level)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    function automatic logic [7:0] ref_fx(input logic [1:0] m, input logic [7:0] x);
        case (m)
            2'd1:    ref_fx = (x > 8'd150) ? 8'd150 : x;
            2'd2:    ref_fx = {x[7:5], 5'b00000};
            2'd3:    ref_fx = x / 8'd2;
            default: ref_fx = x;
        endcase
    endfunction

    // UART TX model: busy for a few cycles after each strobe, then a done pulse
    initial begin
        tx_busy_m = 1'b0;
        tx_done   = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_dv && rst_n) begin
                @(posedge clk); #1;
                tx_busy_m = 1'b1;
                repeat (3) @(posedge clk);
                #1;
                tx_busy_m = 1'b0;
                tx_done   = 1'b1;
                @(posedge clk); #1;
                tx_done   = 1'b0;
            end
        end
    end

    // output monitor / scoreboard pop
    always @(negedge clk) begin
        if (frame_err) err_cnt++;
        if (tx_dv) begin
            if (dv_cnt == 0) first_dv_edge = cyc + 1;
            dv_cnt++;
            if (tx_active) viol++;
            if (exp_q.size() == 0) chk("tx_extra", exp_q.size(), 1);
            else chk("tx_byte", tx_byte, exp_q.pop_front());
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_dv        = 1'b1;
        rx_byte      = b;
        last_rx_edge = cyc + 1;
        @(posedge clk); #1;
        rx_dv = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic send_frame(input logic [1:0] m, input int len);
        mode = m;
        exp_q.push_back(8'hAA);
        exp_q.push_back(8'(len));
        for (int i = 0; i < len; i++) exp_q.push_back(ref_fx(m, pl[i]));
        send_byte(8'hAA);
        send_byte(8'(len));
        for (int i = 0; i < len; i++) send_byte(pl[i]);
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || busy) && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (k >= budget) chk(tag, int'(busy) + exp_q.size(), 0);
        repeat (8) @(posedge clk);
    endtask

    initial begin
        #(40 * 200_000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t1_edge, e0, d0, d1, k;
        rst_n   = 1'b0;
        rx_dv   = 1'b0;
        rx_byte = 8'h00;
        mode    = 2'd0;
        tx_hold = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tx_dv", tx_dv, 0);
        chk("rst_tx_byte", tx_byte, 0);
        chk("rst_busy", busy, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_err", frame_err, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // 1: bypass echo and header latency
        pl[0] = 8'h10; pl[1] = 8'h20; pl[2] = 8'h30;
        send_frame(2'd0, 3);
        t1_edge = last_rx_edge;
        wait_drain("t1_drain", 2000);
        chk("t1_latency", first_dv_edge - t1_edge, 2);
        chk("t1_level", fifo_level, 0);
        chk("t1_err", err_cnt, 0);

        // 2: effect modes
        pl[0] = 8'hC8; pl[1] = 8'h64;
        send_frame(2'd1, 2);
        wait_drain("t2_clip_drain", 2000);
        pl[0] = 8'hFF;
        send_frame(2'd2, 1);
        wait_drain("t2_crush_drain", 2000);
        send_frame(2'd3, 1);
        wait_drain("t2_half_drain", 2000);

        // 3: bad LEN values, then HEADER value as payload
        e0 = err_cnt; d0 = dv_cnt;
        send_byte(8'hAA); send_byte(8'h00);
        send_byte(8'hAA); send_byte(8'h11);
        repeat (10) @(posedge clk);
        chk("t3_err_pulses", err_cnt - e0, 2);
        chk("t3_no_tx", dv_cnt - d0, 0);
        pl[0] = 8'hAA;
        send_frame(2'd0, 1);
        wait_drain("t3_drain", 2000);

        // 4: inter-byte timeout rolls back the partial frame
        e0 = err_cnt; d0 = dv_cnt;
        send_byte(8'hAA); send_byte(8'h04); send_byte(8'h01); send_byte(8'h02);
        repeat (25_010) @(posedge clk);
        chk("t4_err_pulses", err_cnt - e0, 1);
        chk("t4_level", fifo_level, 0);
        chk("t4_no_tx", dv_cnt - d0, 0);
        for (int i = 0; i < 4; i++) pl[i] = 8'(8'h41 + i);
        send_frame(2'd0, 4);
        wait_drain("t4_drain", 2000);

        // 5: two maximum frames pending, third refused at LEN
        @(posedge clk); #1;
        tx_hold = 1'b1;
        e0 = err_cnt;
        for (int i = 0; i < 16; i++) pl[i] = 8'(i * 7 + 3);
        send_frame(2'd0, 16);
        for (int i = 0; i < 16; i++) pl[i] = 8'(8'hF0 - i * 5);
        send_frame(2'd3, 16);
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("t5_level", fifo_level, 32);
        chk("t5_busy", busy, 1);
        send_byte(8'hAA); send_byte(8'h10);
        repeat (4) @(posedge clk);
        chk("t5_queue_full_err", err_cnt - e0, 1);
        @(posedge clk); #1;
        tx_hold = 1'b0;
        wait_drain("t5_drain", 4000);
        chk("t5_level_end", fifo_level, 0);

        // 6: mode change mid-frame has no effect
        mode = 2'd0;
        exp_q.push_back(8'hAA); exp_q.push_back(8'h02);
        exp_q.push_back(8'hC8); exp_q.push_back(8'hC8);
        send_byte(8'hAA); send_byte(8'h02);
        mode = 2'd1;
        send_byte(8'hC8); send_byte(8'hC8);
        wait_drain("t6_drain", 2000);

        // 6b: reset in the middle of payload transmission
        for (int i = 0; i < 8; i++) pl[i] = 8'(8'h80 + i);
        d0 = dv_cnt;
        send_frame(2'd0, 8);
        k = 0;
        while (dv_cnt < d0 + 4 && k < 500) begin
            @(negedge clk);
            k++;
        end
        if (k >= 500) chk("t6_reach_data", dv_cnt - d0, 4);
        @(posedge clk); #1;
        rst_n = 1'b0;
        exp_q.delete();
        d1 = dv_cnt;
        @(negedge clk);
        chk("t6_rst_dv", tx_dv, 0);
        chk("t6_rst_level", fifo_level, 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (60) @(posedge clk);
        chk("t6_post_rst_dv", dv_cnt - d1, 0);
        chk("t6_post_rst_level", fifo_level, 0);
        chk("t6_post_rst_busy", busy, 0);

        chk("dv_while_active", viol, 0);
        chk("sb_leftover", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
